// File: rtl/tnoc_config_pkg.sv
// Shared configuration for the tnoc credit link: width helpers, default sizes,
// VC index type and link flit payload.
package tnoc_config_pkg;

    localparam int unsigned TNOC_CHANNELS   = 2;
    localparam int unsigned TNOC_FLIT_WIDTH = 64;
    localparam int unsigned TNOC_CREDITS    = 8;

    // Counter must hold 0..credits inclusive.
    function automatic int unsigned credit_width(input int unsigned credits);
        return $clog2(credits + 1);
    endfunction

    function automatic int unsigned vc_width(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    localparam int unsigned TNOC_VC_WIDTH = vc_width(TNOC_CHANNELS);

    typedef logic [TNOC_VC_WIDTH-1:0] vc_idx_t;

    typedef struct packed {
        vc_idx_t                    vc;
        logic                       tail;
        logic [TNOC_FLIT_WIDTH-1:0] flit;
    } link_flit_t;

endpackage

// File: rtl/tnoc_credit_counter.sv
// Single-VC credit counter: starts full, decrements on send, increments on
// return, saturates at CREDITS and flags an overflow attempt.
module tnoc_credit_counter
    import tnoc_config_pkg::*;
#(
    parameter int unsigned CREDITS = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             dec,
    input  logic                             inc,
    output logic [credit_width(CREDITS)-1:0] count,
    output logic                             zero,
    output logic                             overflow
);

    localparam int unsigned CW   = credit_width(CREDITS);
    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    logic [CW-1:0] count_next;

    // dec and inc together cancel; a return into a full counter is dropped.
    always_comb begin
        count_next = count;
        overflow   = 1'b0;
        if (dec && !inc && (count != '0)) begin
            count_next = count - CW'(1);
        end else if (inc && !dec) begin
            if (count == FULL) begin
                overflow = 1'b1;
            end else begin
                count_next = count + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= FULL;
        end else begin
            count <= count_next;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tnoc_vc_credit_tx.sv
// Credit-based per-VC link transmitter with a registered valid-only link.
// Optional sticky overflow flag: define TNOC_VC_CREDIT_TX_ERROR_CHECK_EN.
module tnoc_vc_credit_tx
    import tnoc_config_pkg::*;
#(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned FLIT_WIDTH = 64,
    parameter int unsigned CREDITS    = 8,
    parameter int unsigned VC_WIDTH   = vc_width(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [VC_WIDTH-1:0]   i_vc,
    input  logic                  i_tail,
    input  logic [FLIT_WIDTH-1:0] i_flit,
    output logic                  o_valid,
    output logic [VC_WIDTH-1:0]   o_vc,
    output logic                  o_tail,
    output logic [FLIT_WIDTH-1:0] o_flit,
    input  logic [CHANNELS-1:0]   i_credit_return,
    output logic [CHANNELS-1:0]   o_credit_zero,
    output logic                  o_credit_error
);

    localparam int unsigned CW = credit_width(CREDITS);

    typedef struct packed {
        logic [VC_WIDTH-1:0]   vc;
        logic                  tail;
        logic [FLIT_WIDTH-1:0] flit;
    } link_t;

    logic [CHANNELS-1:0] dec;
    logic [CHANNELS-1:0] zero;
    logic [CHANNELS-1:0] overflow;
    logic [CW-1:0]       count [CHANNELS];
    logic                accept;
    link_t               link_q;

    // Out-of-range VC matches no channel and therefore stays not-ready.
    always_comb begin
        o_ready = 1'b0;
        for (int unsigned v = 0; v < CHANNELS; v++) begin
            if (i_vc == VC_WIDTH'(v)) begin
                o_ready = !zero[v];
            end
        end
    end

    assign accept = i_valid & o_ready;

    for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
        assign dec[v] = accept && (i_vc == VC_WIDTH'(v));

        tnoc_credit_counter #(
            .CREDITS (CREDITS)
        ) u_counter (
            .clk      (clk),
            .rst      (rst),
            .dec      (dec[v]),
            .inc      (i_credit_return[v]),
            .count    (count[v]),
            .zero     (zero[v]),
            .overflow (overflow[v])
        );
    end

    // Payload holds when idle; only valid toggles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= 1'b0;
            link_q  <= '0;
        end else begin
            o_valid <= accept;
            if (accept) begin
                link_q <= '{vc: i_vc, tail: i_tail, flit: i_flit};
            end
        end
    end

    assign o_vc          = link_q.vc;
    assign o_tail        = link_q.tail;
    assign o_flit        = link_q.flit;
    assign o_credit_zero = zero;

    logic unused_count;
    always_comb begin
        unused_count = 1'b0;
        for (int unsigned v = 0; v < CHANNELS; v++) begin
            unused_count = unused_count ^ (^count[v]);
        end
    end

`ifdef TNOC_VC_CREDIT_TX_ERROR_CHECK_EN
    logic credit_error_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_error_q <= 1'b0;
        end else if (|overflow) begin
            credit_error_q <= 1'b1;
        end
    end

    assign o_credit_error = credit_error_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(|overflow))
        else $error("credit overflow: return into a full counter");
`else
    logic unused_overflow;
    assign unused_overflow = |overflow;
    assign o_credit_error  = 1'b0;
`endif

endmodule

// File: tb/tb_tnoc_vc_credit_tx.sv
// Randomized and directed bench for tnoc_vc_credit_tx against a per-VC credit model.
module tb_tnoc_vc_credit_tx;

    localparam int CH = 2;
    localparam int FW = 32;
    localparam int CR = 4;
    localparam int VW = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          o_ready;
    logic [VW-1:0] i_vc;
    logic          i_tail;
    logic [FW-1:0] i_flit;
    logic          o_valid;
    logic [VW-1:0] o_vc;
    logic          o_tail;
    logic [FW-1:0] o_flit;
    logic [CH-1:0] i_credit_return;
    logic [CH-1:0] o_credit_zero;
    logic          o_credit_error;

    tnoc_vc_credit_tx #(
        .CHANNELS   (CH),
        .FLIT_WIDTH (FW),
        .CREDITS    (CR),
        .VC_WIDTH   (VW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_vc            (i_vc),
        .i_tail          (i_tail),
        .i_flit          (i_flit),
        .o_valid         (o_valid),
        .o_vc            (o_vc),
        .o_tail          (o_tail),
        .o_flit          (o_flit),
        .i_credit_return (i_credit_return),
        .o_credit_zero   (o_credit_zero),
        .o_credit_error  (o_credit_error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: free downstream slots per VC and the expected link register.
    int            cred [CH];
    logic          m_valid;
    logic [VW-1:0] m_vc;
    logic          m_tail;
    logic [FW-1:0] m_flit;
    logic          m_err;
    logic          m_acc;
    int            m_nc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        if (int'(i_vc) >= CH) return 1'b0;
        return cred[int'(i_vc)] != 0;
    endfunction

    function automatic logic [CH-1:0] model_zero();
        logic [CH-1:0] z;
        for (int v = 0; v < CH; v++) z[v] = (cred[v] == 0);
        return z;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < CH; v++) cred[v] = CR;
            m_valid = 1'b0;
            m_vc    = '0;
            m_tail  = 1'b0;
            m_flit  = '0;
            m_err   = 1'b0;
        end else begin
            m_acc = i_valid && model_ready();
            for (int v = 0; v < CH; v++) begin
                m_nc = cred[v] - ((m_acc && int'(i_vc) == v) ? 1 : 0)
                               + (i_credit_return[v] ? 1 : 0);
                if (m_nc > CR) begin
                    m_nc  = CR;
                    m_err = 1'b1;
                end
                cred[v] = m_nc;
            end
            m_valid = m_acc;
            if (m_acc) begin
                m_vc   = i_vc;
                m_tail = i_tail;
                m_flit = i_flit;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("o_valid", 64'(o_valid), 64'(m_valid));
        chk("o_vc", 64'(o_vc), 64'(m_vc));
        chk("o_tail", 64'(o_tail), 64'(m_tail));
        chk("o_flit", 64'(o_flit), 64'(m_flit));
        chk("o_ready", 64'(o_ready), 64'(model_ready()));
        chk("o_credit_zero", 64'(o_credit_zero), 64'(model_zero()));
`ifdef TNOC_VC_CREDIT_TX_ERROR_CHECK_EN
        chk("o_credit_error", 64'(o_credit_error), 64'(m_err));
`else
        chk("o_credit_error", 64'(o_credit_error), 64'd0);
`endif
    end

    task automatic cycle(input logic v, input logic [VW-1:0] vc, input logic tail,
                         input logic [CH-1:0] ret);
        @(negedge clk);
        #2;
        i_valid         = v;
        i_vc            = vc;
        i_tail          = tail;
        i_flit          = FW'($urandom);
        i_credit_return = ret;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        i_valid = 1'b0;
        i_credit_return = '0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    int seen;

    initial begin
        rst = 1'b1;
        i_valid = 1'b0;
        i_vc = '0;
        i_tail = 1'b0;
        i_flit = '0;
        i_credit_return = '0;
        #1;
        chk("reset o_valid", 64'(o_valid), 64'd0);
        chk("reset o_credit_zero", 64'(o_credit_zero), 64'd0);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;

        // Six back-to-back VC0 flits: only four fit.
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(i < 6, 1'b0, i == 5, 2'b00);
            if (o_valid) seen++;
        end
        chk("vc0 accepted flits", 64'(seen), 64'd4);
        #1;
        chk("vc0 exhausted ready", 64'(o_ready), 64'd0);
        chk("vc0 exhausted zero", 64'(o_credit_zero), 64'(2'b01));

        // One return reopens exactly one slot.
        cycle(1'b0, 1'b0, 1'b0, 2'b01);
        cycle(1'b1, 1'b0, 1'b1, 2'b00);
        #1;
        chk("ready after return", 64'(o_ready), 64'd1);
        cycle(1'b0, 1'b0, 1'b0, 2'b00);
        #1;
        chk("vc0 drained again", 64'(o_credit_zero), 64'(2'b01));

        // VC1 to 2 credits, then simultaneous accept and return keeps it at 2.
        cycle(1'b1, 1'b1, 1'b0, 2'b00);
        cycle(1'b1, 1'b1, 1'b0, 2'b00);
        cycle(1'b1, 1'b1, 1'b1, 2'b10);
        cycle(1'b0, 1'b0, 1'b0, 2'b00);
        #1;
        chk("same-cycle link valid", 64'(o_valid), 64'd1);
        chk("same-cycle link vc", 64'(o_vc), 64'd1);
        cycle(1'b1, 1'b1, 1'b0, 2'b00);
        cycle(1'b1, 1'b1, 1'b1, 2'b00);
        cycle(1'b0, 1'b0, 1'b0, 2'b00);
        #1;
        chk("vc1 stayed at two", 64'(o_credit_zero), 64'(2'b11));

        // Refill VC1 and interleave with exhausted VC0: only VC1 gets through.
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 2'b10);
        seen = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(i < 8, VW'(i % 2), (i % 4) >= 2, 2'b00);
            if (o_valid) begin
                seen++;
                chk("interleave vc", 64'(o_vc), 64'd1);
            end
        end
        chk("interleave accepted", 64'(seen), 64'd4);

        // Return into a full counter saturates.
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 2'b01);
        cycle(1'b0, 1'b0, 1'b0, 2'b00);
        #1;
        chk("overflow zero", 64'(o_credit_zero), 64'd0);
        chk("overflow ready", 64'(o_ready), 64'd1);
`ifdef TNOC_VC_CREDIT_TX_ERROR_CHECK_EN
        chk("overflow error", 64'(o_credit_error), 64'd1);
`else
        chk("overflow error", 64'(o_credit_error), 64'd0);
`endif

        // Random traffic with random returns.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7, VW'($urandom_range(0, CH - 1)),
                  1'($urandom), {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)});
        end

        // Asynchronous reset while the link is busy and VC0 has one credit left.
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 2'b00);
        cycle(1'b1, 1'b0, 1'b0, 2'b00);
        cycle(1'b1, 1'b0, 1'b1, 2'b00);
        cycle(1'b0, 1'b0, 1'b0, 2'b00);
        #1;
        chk("pre-reset valid", 64'(o_valid), 64'd1);
        chk("pre-reset zero", 64'(o_credit_zero), 64'd0);
        rst = 1'b1;
        #1;
        chk("async reset valid", 64'(o_valid), 64'd0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        i_vc = 1'b0;
        #1;
        chk("post-reset ready vc0", 64'(o_ready), 64'd1);
        i_vc = 1'b1;
        #1;
        chk("post-reset ready vc1", 64'(o_ready), 64'd1);
        chk("post-reset zero", 64'(o_credit_zero), 64'd0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 2'b00);

        @(negedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
